// File: rtl/write_back.sv
// write_back -- final pipeline stage.
//
// Commits the execute-to-write bundle: register-file writes, the 4-bit Flags
// field update, a second register write for the upper word of 64-bit results,
// and memory stores. All write outputs are registered one cycle after the
// accepting edge. Stores hold mem_write/mem_address/mem_data stable until
// mem_ready is seen.
//
// Optional feature: define RETIRE_COUNTER_EN to add the retired_count output,
// a wrapping count of fully completed (non-flushed) instructions.
//
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   in_valid / in_hold     upstream bundle valid / stall back to upstream
//   in_*                   execute-to-write bundle fields (in_pc is diagnostic)
//   reg_read_index/value   combinational register read (store address base)
//   reg_we/windex/wvalue   register-file write port
//   flags_we/flags_value   Flags[FLAGS_LSB+3:FLAGS_LSB] field write
//   mem_write/address/data store request, held until mem_ready
//   retired_count          retired-instruction counter (RETIRE_COUNTER_EN only)
module write_back #(
    parameter int REG_INDEX_W = 5,
    parameter int FLAGS_INDEX = 31,
    parameter int FLAGS_LSB   = 27
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_hold,
    input  logic [31:0]            in_pc,
    input  logic [REG_INDEX_W-1:0] in_target_register,
    input  logic                   in_is_writing_memory,
    input  logic [3:0]             in_flags,
    input  logic [31:0]            in_target_value,
    input  logic                   in_has_upper_value,
    input  logic [31:0]            in_upper_value,
    input  logic [31:0]            in_adjustment_value,
    input  logic                   in_has_flushed,
    output logic [REG_INDEX_W-1:0] reg_read_index,
    input  logic [31:0]            reg_read_value,
    output logic                   reg_we,
    output logic [REG_INDEX_W-1:0] reg_windex,
    output logic [31:0]            reg_wvalue,
    output logic                   flags_we,
    output logic [3:0]             flags_value,
    output logic                   mem_write,
    output logic [31:0]            mem_address,
    output logic [31:0]            mem_data,
    input  logic                   mem_ready
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [31:0]            retired_count
`endif
);

    typedef enum logic [1:0] {IDLE, UPPER, MEM} state_t;

    localparam logic [REG_INDEX_W-1:0] FLAGS_IDX = REG_INDEX_W'(FLAGS_INDEX);
    localparam logic [REG_INDEX_W-1:0] ONE_IDX   = REG_INDEX_W'(1);

    state_t                   state_q, state_d;
    logic                     reg_we_q, reg_we_d;
    logic [REG_INDEX_W-1:0]   reg_windex_q, reg_windex_d;
    logic [31:0]              reg_wvalue_q, reg_wvalue_d;
    logic                     flags_we_q, flags_we_d;
    logic [3:0]               flags_value_q, flags_value_d;
    logic                     mem_write_q, mem_write_d;
    logic [31:0]              mem_address_q, mem_address_d;
    logic [31:0]              mem_data_q, mem_data_d;
    logic [REG_INDEX_W-1:0]   upper_index_q, upper_index_d;
    logic [31:0]              upper_value_q, upper_value_d;
    logic                     accept;
    logic                     retire;

    // in_pc is carried for debug visibility only; FLAGS_LSB describes where the
    // register file places the field and does not affect this stage's logic.
    logic unused_ok;
    assign unused_ok = ^{in_pc, 32'(FLAGS_LSB)};

    assign accept         = (state_q == IDLE) && in_valid;
    assign in_hold        = in_valid && (state_q != IDLE);
    assign reg_read_index = in_target_register;

    always_comb begin
        state_d       = state_q;
        reg_we_d      = 1'b0;
        reg_windex_d  = reg_windex_q;
        reg_wvalue_d  = reg_wvalue_q;
        flags_we_d    = 1'b0;
        flags_value_d = flags_value_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        upper_index_d = upper_index_q;
        upper_value_d = upper_value_q;
        retire        = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && !in_has_flushed) begin
                    if (in_is_writing_memory) begin
                        mem_write_d   = 1'b1;
                        mem_address_d = reg_read_value + in_adjustment_value;
                        mem_data_d    = in_target_value;
                        state_d       = MEM;
                    end else begin
                        // r0 is hardwired; a direct write of Flags overrides
                        // the implicit flags update of the same instruction.
                        reg_we_d     = (in_target_register != '0);
                        reg_windex_d = in_target_register;
                        reg_wvalue_d = in_target_value;
                        if (in_target_register != FLAGS_IDX) begin
                            flags_we_d    = 1'b1;
                            flags_value_d = in_flags;
                        end
                        if (in_has_upper_value) begin
                            // Index wraps modulo the register count.
                            upper_index_d = in_target_register + ONE_IDX;
                            upper_value_d = in_upper_value;
                            state_d       = UPPER;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                end
            end
            UPPER: begin
                reg_we_d     = (upper_index_q != '0);
                reg_windex_d = upper_index_q;
                reg_wvalue_d = upper_value_q;
                state_d      = IDLE;
                retire       = 1'b1;
            end
            MEM: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                    retire      = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            reg_we_q      <= 1'b0;
            reg_windex_q  <= '0;
            reg_wvalue_q  <= '0;
            flags_we_q    <= 1'b0;
            flags_value_q <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            reg_we_q      <= reg_we_d;
            reg_windex_q  <= reg_windex_d;
            reg_wvalue_q  <= reg_wvalue_d;
            flags_we_q    <= flags_we_d;
            flags_value_q <= flags_value_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
        end
    end

    // Upper-word latch is only meaningful while in UPPER, so it needs no reset.
    always_ff @(posedge clock) begin
        upper_index_q <= upper_index_d;
        upper_value_q <= upper_value_d;
    end

    assign reg_we      = reg_we_q;
    assign reg_windex  = reg_windex_q;
    assign reg_wvalue  = reg_wvalue_q;
    assign flags_we    = flags_we_q;
    assign flags_value = flags_value_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] retired_count_q, retired_count_d;

    always_comb begin
        retired_count_d = retired_count_q + 32'(retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count_q <= '0;
        end else begin
            retired_count_q <= retired_count_d;
        end
    end

    assign retired_count = retired_count_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_write_back.sv
// Testbench for write_back: directed scenarios followed by randomized bundles.
// The driver pushes the expected register, flags and store events (with the
// cycle they must appear in) into queues; a monitor pops and compares them
// whenever the DUT raises a write output.
module tb_write_back;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_hold;
    logic [31:0] in_pc;
    logic [4:0]  in_target_register;
    logic        in_is_writing_memory;
    logic [3:0]  in_flags;
    logic [31:0] in_target_value;
    logic        in_has_upper_value;
    logic [31:0] in_upper_value;
    logic [31:0] in_adjustment_value;
    logic        in_has_flushed;
    logic [4:0]  reg_read_index;
    logic [31:0] reg_read_value;
    logic        reg_we;
    logic [4:0]  reg_windex;
    logic [31:0] reg_wvalue;
    logic        flags_we;
    logic [3:0]  flags_value;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_ready;
`ifdef RETIRE_COUNTER_EN
    logic [31:0] retired_count;
`endif

    write_back dut (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid),
        .in_hold              (in_hold),
        .in_pc                (in_pc),
        .in_target_register   (in_target_register),
        .in_is_writing_memory (in_is_writing_memory),
        .in_flags             (in_flags),
        .in_target_value      (in_target_value),
        .in_has_upper_value   (in_has_upper_value),
        .in_upper_value       (in_upper_value),
        .in_adjustment_value  (in_adjustment_value),
        .in_has_flushed       (in_has_flushed),
        .reg_read_index       (reg_read_index),
        .reg_read_value       (reg_read_value),
        .reg_we               (reg_we),
        .reg_windex           (reg_windex),
        .reg_wvalue           (reg_wvalue),
        .flags_we             (flags_we),
        .flags_value          (flags_value),
        .mem_write            (mem_write),
        .mem_address          (mem_address),
        .mem_data             (mem_data),
        .mem_ready            (mem_ready)
`ifdef RETIRE_COUNTER_EN
        ,
        .retired_count        (retired_count)
`endif
    );

    always #5 clock = ~clock;

    // Static register file contents seen through the combinational read port.
    logic [31:0] rf [32];
    assign reg_read_value = rf[reg_read_index];

    typedef struct { int cyc; logic [4:0] idx; logic [31:0] val; } reg_exp_t;
    typedef struct { int cyc; logic [3:0] f; } flag_exp_t;
    typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; int len; } mem_exp_t;

    reg_exp_t  rq[$];
    flag_exp_t fq[$];
    mem_exp_t  mq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_retired = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    bit       mem_active = 1'b0;
    int       mem_cnt = 0;
    mem_exp_t cur_mem;

    initial begin
        reg_exp_t  re;
        flag_exp_t fe;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (reset) begin
                mem_active = 1'b0;
                continue;
            end
            if (reg_we) begin
                if (rq.size() == 0) begin
                    chk("reg_we unexpected", 32'(reg_windex), 32'hFFFF_FFFF);
                end else begin
                    re = rq.pop_front();
                    chk("reg_windex", 32'(reg_windex), 32'(re.idx));
                    chk("reg_wvalue", reg_wvalue, re.val);
                    chk("reg_cycle", cyc, re.cyc);
                end
            end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                re = rq.pop_front();
                chk("reg_we missing", 32'(reg_we), 32'd1);
            end
            if (flags_we) begin
                if (fq.size() == 0) begin
                    chk("flags_we unexpected", 32'(flags_we), 32'd0);
                end else begin
                    fe = fq.pop_front();
                    chk("flags_value", 32'(flags_value), 32'(fe.f));
                    chk("flags_cycle", cyc, fe.cyc);
                end
            end else if (fq.size() != 0 && fq[0].cyc <= cyc) begin
                fe = fq.pop_front();
                chk("flags_we missing", 32'(flags_we), 32'd1);
            end
            if (mem_write) begin
                if (!mem_active) begin
                    if (mq.size() == 0) begin
                        chk("mem_write unexpected", 32'(mem_write), 32'd0);
                        cur_mem.addr = mem_address;
                        cur_mem.data = mem_data;
                        cur_mem.len  = 0;
                    end else begin
                        cur_mem = mq.pop_front();
                        chk("mem_address", mem_address, cur_mem.addr);
                        chk("mem_data", mem_data, cur_mem.data);
                        chk("mem_cycle", cyc, cur_mem.cyc);
                    end
                    mem_active = 1'b1;
                    mem_cnt = 1;
                end else begin
                    chk("mem_address held", mem_address, cur_mem.addr);
                    chk("mem_data held", mem_data, cur_mem.data);
                    mem_cnt++;
                end
            end else if (mem_active) begin
                chk("mem_write length", mem_cnt, cur_mem.len);
                mem_active = 1'b0;
            end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
                cur_mem = mq.pop_front();
                chk("mem_write missing", 32'(mem_write), 32'd1);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid  = 1'b0;
            mem_ready = 1'($urandom);
            in_target_register = 5'($urandom);
            in_has_flushed = 1'($urandom);
        end
    endtask

    task automatic send_reg(input logic [4:0] t, input logic [31:0] v, input logic [3:0] f,
                            input bit hu, input logic [31:0] uv, input bit fl);
        reg_exp_t  re;
        flag_exp_t fe;
        logic [4:0] ui;
        @(negedge clock);
        in_valid             = 1'b1;
        in_pc                = $urandom;
        in_target_register   = t;
        in_is_writing_memory = 1'b0;
        in_flags             = f;
        in_target_value      = v;
        in_has_upper_value   = hu;
        in_upper_value       = uv;
        in_adjustment_value  = $urandom;
        in_has_flushed       = fl;
        mem_ready            = 1'($urandom);
        if (!fl) begin
            if (t != 5'd0) begin
                re.cyc = cyc + 1; re.idx = t; re.val = v;
                rq.push_back(re);
            end
            if (t != 5'd31) begin
                fe.cyc = cyc + 1; fe.f = f;
                fq.push_back(fe);
            end
            if (hu) begin
                ui = t + 5'd1;
                if (ui != 5'd0) begin
                    re.cyc = cyc + 2; re.idx = ui; re.val = uv;
                    rq.push_back(re);
                end
            end
            exp_retired++;
        end
        #1 chk("in_hold at accept", 32'(in_hold), 32'd0);
        if (hu && !fl) begin
            @(negedge clock);
            mem_ready = 1'($urandom);
            #1 chk("in_hold during upper", 32'(in_hold), 32'd1);
        end
    endtask

    task automatic send_store(input logic [4:0] t, input logic [31:0] adj, input logic [31:0] d,
                              input int dly, input bit fl);
        mem_exp_t me;
        @(negedge clock);
        in_valid             = 1'b1;
        in_pc                = $urandom;
        in_target_register   = t;
        in_is_writing_memory = 1'b1;
        in_flags             = 4'($urandom);
        in_target_value      = d;
        in_has_upper_value   = 1'b0;
        in_upper_value       = $urandom;
        in_adjustment_value  = adj;
        in_has_flushed       = fl;
        mem_ready            = 1'($urandom);
        if (!fl) begin
            me.cyc = cyc + 1; me.addr = rf[t] + adj; me.data = d; me.len = dly + 1;
            mq.push_back(me);
            exp_retired++;
        end
        #1 chk("in_hold at store accept", 32'(in_hold), 32'd0);
        if (!fl) begin
            repeat (dly) begin
                @(negedge clock);
                mem_ready = 1'b0;
                #1 chk("in_hold during mem", 32'(in_hold), 32'd1);
            end
            @(negedge clock);
            mem_ready = 1'b1;
            #1 chk("in_hold at mem_ready", 32'(in_hold), 32'd1);
        end
    endtask

    initial begin
        int k;
        int r;
        logic [4:0] t;
        bit fl;
        mem_exp_t me;

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        reset = 1'b1;
        in_valid = 1'b0;
        in_pc = '0;
        in_target_register = '0;
        in_is_writing_memory = 1'b0;
        in_flags = '0;
        in_target_value = '0;
        in_has_upper_value = 1'b0;
        in_upper_value = '0;
        in_adjustment_value = '0;
        in_has_flushed = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset reg_we", 32'(reg_we), 32'd0);
        chk("reset flags_we", 32'(flags_we), 32'd0);
        chk("reset mem_write", 32'(mem_write), 32'd0);
        chk("reset reg_windex", 32'(reg_windex), 32'd0);
        chk("reset reg_wvalue", reg_wvalue, 32'd0);
        chk("reset flags_value", 32'(flags_value), 32'd0);
        chk("reset mem_address", mem_address, 32'd0);
        chk("reset mem_data", mem_data, 32'd0);
        chk("reset in_hold", 32'(in_hold), 32'd0);
`ifdef RETIRE_COUNTER_EN
        chk("reset retired_count", retired_count, 32'd0);
`endif
        reset = 1'b0;

        // Directed scenarios
        send_reg(5'd5, 32'h1234, 4'b1001, 1'b0, 32'h0, 1'b0);
        send_reg(5'd7, 32'h1, 4'b0110, 1'b1, 32'hDEAD, 1'b0);
        send_reg(5'd9, 32'h55, 4'b0011, 1'b0, 32'h0, 1'b0);
        rf[3] = 32'h1000;
        send_store(5'd3, 32'h10, 32'hAA, 3, 1'b0);
        send_reg(5'd0, 32'hFF, 4'b1100, 1'b0, 32'h0, 1'b0);
        send_reg(5'd31, 32'h4000_0000, 4'b1010, 1'b0, 32'h0, 1'b0);
        send_store(5'd4, $urandom, $urandom, 0, 1'b1);
        send_reg(5'd31, 32'h77, 4'b0101, 1'b1, 32'hBEEF, 1'b0);
        idle(2);

        // Reset while a store waits for mem_ready: the store is dropped.
        @(negedge clock);
        in_valid = 1'b1;
        in_is_writing_memory = 1'b1;
        in_has_flushed = 1'b0;
        in_target_register = 5'd6;
        in_adjustment_value = 32'h4;
        in_target_value = 32'h5A5A;
        mem_ready = 1'b0;
        me.cyc = cyc + 1; me.addr = rf[6] + 32'h4; me.data = 32'h5A5A; me.len = 0;
        mq.push_back(me);
        @(negedge clock);
        chk("mem_write before reset", 32'(mem_write), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("reset mid-mem mem_write", 32'(mem_write), 32'd0);
        chk("reset mid-mem in_hold", 32'(in_hold), 32'd0);
        chk("reset mid-mem mem_address", mem_address, 32'd0);
        exp_retired = 0;
`ifdef RETIRE_COUNTER_EN
        chk("reset mid-mem retired_count", retired_count, 32'd0);
`endif
        reset = 1'b0;
        in_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            r = $urandom_range(0, 7);
            t = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 30));
            fl = ($urandom_range(0, 9) == 0);
            if (k < 3) send_store(t, $urandom, $urandom, $urandom_range(0, 4), fl);
            else send_reg(t, $urandom, 4'($urandom), ($urandom_range(0, 2) == 0), $urandom, fl);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        chk("reg queue drained", rq.size(), 32'd0);
        chk("flags queue drained", fq.size(), 32'd0);
        chk("mem queue drained", mq.size(), 32'd0);
`ifdef RETIRE_COUNTER_EN
        chk("retired_count", retired_count, exp_retired);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
